// File: rtl/calendar_pkg.sv
// Shared constants and BCD helpers for the date stage of the digital clock.
package calendar_pkg;

  localparam logic [7:0] M_JAN = 8'h01, M_FEB = 8'h02, M_MAR = 8'h03, M_APR = 8'h04;
  localparam logic [7:0] M_MAY = 8'h05, M_JUN = 8'h06, M_JUL = 8'h07, M_AUG = 8'h08;
  localparam logic [7:0] M_SEP = 8'h09, M_OCT = 8'h10, M_NOV = 8'h11, M_DEC = 8'h12;

  typedef enum logic [1:0] {
    SEL_DAY   = 2'd0,
    SEL_MONTH = 2'd1,
    SEL_YEAR  = 2'd2,
    SEL_WDAY  = 2'd3
  } sel_e;

  localparam logic [7:0] D28 = 8'h28, D29 = 8'h29, D30 = 8'h30, D31 = 8'h31;

  // Divisibility by 4 read straight off the digits: only the tens parity matters.
  function automatic logic bcd_mod4(input logic [7:0] v);
    if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
  endfunction

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return 8'h00;
  endfunction

  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [7:0] hi;
    hi = (v[7:0] == 8'h99) ? bcd_inc2(v[15:8]) : v[15:8];
    return {hi, bcd_inc2(v[7:0])};
  endfunction

  // Century years (yy == 00) are leap only when the century digits divide by 4.
  function automatic logic is_leap_year(input logic [15:0] y);
    return (y[7:0] == 8'h00) ? bcd_mod4(y[15:8]) : bcd_mod4(y[7:0]);
  endfunction

endpackage

// File: rtl/month_days.sv
// Last valid BCD day of a month, given whether the year is a leap year.
module month_days
  import calendar_pkg::*;
(
  input  logic [7:0] month_bcd,
  input  logic       leap,
  output logic [7:0] last_day_bcd
);

  always_comb begin
    case (month_bcd)
      M_APR, M_JUN, M_SEP, M_NOV: last_day_bcd = D30;
      M_FEB:                      last_day_bcd = leap ? D29 : D28;
      default:                    last_day_bcd = D31;
    endcase
  end

endmodule

// File: rtl/calendar_bcd.sv
// BCD day/month/year calendar advanced by the hour counter's day rollover pulse.
// Optional weekday register and port are built when CALENDAR_WEEKDAY_EN is defined.
module calendar_bcd
  import calendar_pkg::*;
#(
  parameter logic [15:0] YEAR_INIT  = 16'h2000,
  parameter logic [7:0]  MONTH_INIT = 8'h01,
  parameter logic [7:0]  DAY_INIT   = 8'h01
`ifdef CALENDAR_WEEKDAY_EN
  , parameter logic [2:0] WEEKDAY_INIT = 3'd6
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        day_tick,
  input  logic        set_mode,
  input  logic [1:0]  set_sel,
  input  logic        set_inc,
  output logic [7:0]  day_bcd,
  output logic [7:0]  month_bcd,
  output logic [15:0] year_bcd,
  output logic        leap,
`ifdef CALENDAR_WEEKDAY_EN
  output logic [2:0]  weekday,
`endif
  output logic        year_carry
);

  logic [7:0]  day_n, month_n, last_cur, last_edit, month_wrap, edit_month;
  logic [15:0] year_n, year_inc, edit_year;
  logic        carry_n, edit_leap;
`ifdef CALENDAR_WEEKDAY_EN
  logic [2:0]  wday_n, wday_adv;
  assign wday_adv = (weekday == 3'd6) ? 3'd0 : weekday + 3'd1;
`endif

  assign leap       = is_leap_year(year_bcd);
  assign month_wrap = (month_bcd == M_DEC) ? M_JAN : bcd_inc2(month_bcd);
  assign year_inc   = bcd_inc4(year_bcd);

  // The date as it would look after a set-mode month/year edit, used for clamping the day.
  assign edit_month = (set_sel == SEL_MONTH) ? month_wrap : month_bcd;
  assign edit_year  = (set_sel == SEL_YEAR)  ? year_inc   : year_bcd;
  assign edit_leap  = is_leap_year(edit_year);

  month_days u_cur_days  (.month_bcd(month_bcd),  .leap(leap),      .last_day_bcd(last_cur));
  month_days u_edit_days (.month_bcd(edit_month), .leap(edit_leap), .last_day_bcd(last_edit));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    day_n   = day_bcd;
    month_n = month_bcd;
    year_n  = year_bcd;
    carry_n = 1'b0;
`ifdef CALENDAR_WEEKDAY_EN
    wday_n  = weekday;
`endif
    if (set_mode) begin
      if (set_inc) begin
        case (set_sel)
          SEL_DAY: day_n = (day_bcd == last_cur) ? 8'h01 : bcd_inc2(day_bcd);
          SEL_MONTH, SEL_YEAR: begin
            month_n = edit_month;
            year_n  = edit_year;
            day_n   = (day_bcd > last_edit) ? last_edit : day_bcd;
          end
          default: begin
`ifdef CALENDAR_WEEKDAY_EN
            wday_n = wday_adv;
`endif
          end
        endcase
      end
    end else if (day_tick) begin
`ifdef CALENDAR_WEEKDAY_EN
      wday_n = wday_adv;
`endif
      if (day_bcd != last_cur) begin
        day_n = bcd_inc2(day_bcd);
      end else begin
        day_n   = 8'h01;
        month_n = month_wrap;
        if (month_bcd == M_DEC) begin
          year_n  = year_inc;
          carry_n = (year_bcd == 16'h9999);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_bcd    <= DAY_INIT;
      month_bcd  <= MONTH_INIT;
      year_bcd   <= YEAR_INIT;
      year_carry <= 1'b0;
`ifdef CALENDAR_WEEKDAY_EN
      weekday    <= WEEKDAY_INIT;
`endif
    end else begin
      // NOTE: non-blocking updates so every field samples the pre-edge date.
      day_bcd    <= day_n;
      month_bcd  <= month_n;
      year_bcd   <= year_n;
      year_carry <= carry_n;
`ifdef CALENDAR_WEEKDAY_EN
      weekday    <= wday_n;
`endif
    end
  end

endmodule
